// File: rtl/vx_csr_rmw_unit.sv
// CSR read-modify-write stage: reads the store, writes the new value, returns the old value one cycle later.
// Single registered output entry; in_ready stalls only while it is full and not draining. Optional VX_CSR_RMW_PERF_EN adds counters.
module vx_csr_rmw_unit #(
    parameter int NUM_THREADS   = 4,
    parameter int NW_WIDTH      = 2,
    parameter int UUID_WIDTH    = 44,
    parameter int XLEN          = 32,
    parameter int NR_BITS       = 5,
    parameter int CSR_ADDR_BITS = 12,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [UUID_WIDTH-1:0]         in_uuid,
    input  logic [NW_WIDTH-1:0]           in_wid,
    input  logic [NUM_THREADS-1:0]        in_tmask,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [NR_BITS-1:0]            in_rd,
    input  logic                          in_wb,
    input  logic [1:0]                    in_op,
    input  logic                          in_use_imm,
    input  logic [4:0]                    in_imm,
    input  logic [CSR_ADDR_BITS-1:0]      in_addr,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs1_data,
    output logic                          csr_read_enable,
    output logic [UUID_WIDTH-1:0]         csr_read_uuid,
    output logic [NW_WIDTH-1:0]           csr_read_wid,
    output logic [CSR_ADDR_BITS-1:0]      csr_read_addr,
    input  logic [XLEN-1:0]               csr_read_data_ro,
    input  logic [XLEN-1:0]               csr_read_data_rw,
    output logic                          csr_write_enable,
    output logic [UUID_WIDTH-1:0]         csr_write_uuid,
    output logic [NW_WIDTH-1:0]           csr_write_wid,
    output logic [CSR_ADDR_BITS-1:0]      csr_write_addr,
    output logic [XLEN-1:0]               csr_write_data,
`ifdef VX_CSR_RMW_PERF_EN
    output logic [PERF_CTR_BITS-1:0]      perf_csr_reqs,
    output logic [PERF_CTR_BITS-1:0]      perf_csr_stalls,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [UUID_WIDTH-1:0]         out_uuid,
    output logic [NW_WIDTH-1:0]           out_wid,
    output logic [NUM_THREADS-1:0]        out_tmask,
    output logic [XLEN-1:0]               out_pc,
    output logic [NR_BITS-1:0]            out_rd,
    output logic                          out_wb,
    output logic [NUM_THREADS*XLEN-1:0]   out_data
);

    localparam logic [1:0] OP_R  = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic            fire;
    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;

    // Holding reset_n in the ready term keeps both store strobes quiet during reset.
    assign in_ready = reset_n && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;

    // Lowest active lane wins; falls back to lane 0 when the mask is empty.
    always_comb begin
        rs1_sel = in_rs1_data[XLEN-1:0];
        for (int i = NUM_THREADS-1; i >= 0; i--) begin
            if (in_tmask[i]) rs1_sel = in_rs1_data[i*XLEN +: XLEN];
        end
    end

    assign operand = in_use_imm ? {{(XLEN-5){1'b0}}, in_imm} : rs1_sel;
    assign old_val = csr_read_data_ro | csr_read_data_rw;

    always_comb begin
        new_val = old_val;
        case (in_op)
            OP_RW:   new_val = operand;
            OP_RS:   new_val = old_val | operand;
            OP_RC:   new_val = old_val & ~operand;
            default: new_val = old_val;
        endcase
    end

    assign csr_read_enable  = fire;
    assign csr_read_uuid    = in_uuid;
    assign csr_read_wid     = in_wid;
    assign csr_read_addr    = in_addr;

    assign csr_write_enable = fire && ((in_op == OP_RW) ||
                              (((in_op == OP_RS) || (in_op == OP_RC)) && (operand != '0)));
    assign csr_write_uuid   = in_uuid;
    assign csr_write_wid    = in_wid;
    assign csr_write_addr   = in_addr;
    assign csr_write_data   = new_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_uuid  <= '0;
            out_wid   <= '0;
            out_tmask <= '0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_wb    <= 1'b0;
            out_data  <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_uuid  <= in_uuid;
            out_wid   <= in_wid;
            out_tmask <= in_tmask;
            out_pc    <= in_pc;
            out_rd    <= in_rd;
            out_wb    <= in_wb;
            out_data  <= {NUM_THREADS{old_val}};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef VX_CSR_RMW_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_csr_reqs   <= '0;
            perf_csr_stalls <= '0;
        end else begin
            if (fire)                   perf_csr_reqs   <= perf_csr_reqs + 1'b1;
            if (in_valid && !in_ready)  perf_csr_stalls <= perf_csr_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_csr_rmw_unit.sv
// Directed bench for vx_csr_rmw_unit: fixed vectors with hand-computed results, checked by immediate assertions.
module tb_vx_csr_rmw_unit;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [43:0]  in_uuid;
    logic [1:0]   in_wid;
    logic [3:0]   in_tmask;
    logic [31:0]  in_pc;
    logic [4:0]   in_rd;
    logic         in_wb;
    logic [1:0]   in_op;
    logic         in_use_imm;
    logic [4:0]   in_imm;
    logic [11:0]  in_addr;
    logic [127:0] in_rs1_data;
    logic         csr_read_enable;
    logic [43:0]  csr_read_uuid;
    logic [1:0]   csr_read_wid;
    logic [11:0]  csr_read_addr;
    logic [31:0]  csr_read_data_ro;
    logic [31:0]  csr_read_data_rw;
    logic         csr_write_enable;
    logic [43:0]  csr_write_uuid;
    logic [1:0]   csr_write_wid;
    logic [11:0]  csr_write_addr;
    logic [31:0]  csr_write_data;
    logic         out_valid;
    logic         out_ready;
    logic [43:0]  out_uuid;
    logic [1:0]   out_wid;
    logic [3:0]   out_tmask;
    logic [31:0]  out_pc;
    logic [4:0]   out_rd;
    logic         out_wb;
    logic [127:0] out_data;
`ifdef VX_CSR_RMW_PERF_EN
    logic [43:0]  perf_csr_reqs;
    logic [43:0]  perf_csr_stalls;
`endif

    int total = 0;
    int bad   = 0;

    // Tiny backing store for 0x340 so the back-to-back case sees real written data.
    logic        use_store = 1'b0;
    logic [31:0] store_q   = 32'h0;
    logic [31:0] rw_drv    = 32'h0;

    assign csr_read_data_rw = use_store ? ((csr_read_addr == 12'h340) ? store_q : 32'h0) : rw_drv;

    always @(posedge clk) begin
        if (csr_write_enable && csr_write_addr == 12'h340) store_q <= csr_write_data;
    end

    vx_csr_rmw_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_uuid          (in_uuid),
        .in_wid           (in_wid),
        .in_tmask         (in_tmask),
        .in_pc            (in_pc),
        .in_rd            (in_rd),
        .in_wb            (in_wb),
        .in_op            (in_op),
        .in_use_imm       (in_use_imm),
        .in_imm           (in_imm),
        .in_addr          (in_addr),
        .in_rs1_data      (in_rs1_data),
        .csr_read_enable  (csr_read_enable),
        .csr_read_uuid    (csr_read_uuid),
        .csr_read_wid     (csr_read_wid),
        .csr_read_addr    (csr_read_addr),
        .csr_read_data_ro (csr_read_data_ro),
        .csr_read_data_rw (csr_read_data_rw),
        .csr_write_enable (csr_write_enable),
        .csr_write_uuid   (csr_write_uuid),
        .csr_write_wid    (csr_write_wid),
        .csr_write_addr   (csr_write_addr),
        .csr_write_data   (csr_write_data),
`ifdef VX_CSR_RMW_PERF_EN
        .perf_csr_reqs    (perf_csr_reqs),
        .perf_csr_stalls  (perf_csr_stalls),
`endif
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_uuid         (out_uuid),
        .out_wid          (out_wid),
        .out_tmask        (out_tmask),
        .out_pc           (out_pc),
        .out_rd           (out_rd),
        .out_wb           (out_wb),
        .out_data         (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [1:0] op, input logic [11:0] addr, input logic [3:0] tmask,
                       input logic imm_en, input logic [4:0] imm, input logic [127:0] rs1,
                       input logic [31:0] pc);
        in_valid    = 1'b1;
        in_op       = op;
        in_addr     = addr;
        in_tmask    = tmask;
        in_use_imm  = imm_en;
        in_imm      = imm;
        in_rs1_data = rs1;
        in_pc       = pc;
        in_uuid     = {12'h0, pc};
        in_wid      = pc[1:0];
        in_rd       = pc[6:2];
        in_wb       = 1'b1;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check(tag, out_valid, 1'b0);
    endtask

    initial begin
        reset_n          = 1'b0;
        out_ready        = 1'b1;
        csr_read_data_ro = 32'h0;
        req(2'b01, 12'h340, 4'b1111, 1'b0, 5'd0, {4{32'h5555AAAA}}, 32'h0);
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 128'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_rd_en", csr_read_enable, 1'b0);
        check("rst_wr_en", csr_write_enable, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // CSRRW 0x340: write rs1 lane 0, return old value on every lane.
        @(negedge clk);
        rw_drv = 32'h12345678;
        req(2'b01, 12'h340, 4'b1111, 1'b0, 5'd0,
            {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF}, 32'h80000010);
        #1;
        check("rw_in_ready", in_ready, 1'b1);
        check("rw_rd_en", csr_read_enable, 1'b1);
        check("rw_rd_addr", csr_read_addr, 12'h340);
        check("rw_rd_uuid", csr_read_uuid, 44'h80000010);
        check("rw_wr_en", csr_write_enable, 1'b1);
        check("rw_wr_addr", csr_write_addr, 12'h340);
        check("rw_wr_wid", csr_write_wid, 2'd0);
        check("rw_wr_data", csr_write_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("rw_out_valid", out_valid, 1'b1);
        check("rw_out_data", out_data, {4{32'h12345678}});
        check("rw_out_pc", out_pc, 32'h80000010);
        check("rw_out_uuid", out_uuid, 44'h80000010);
        check("rw_out_rd", out_rd, 5'd4);
        check("rw_out_tmask", out_tmask, 4'b1111);
        check("rw_out_wb", out_wb, 1'b1);
        idle_cycle("rw_drain");

        // CSRRSI with zimm 0: read only, no write even though rs1 is nonzero.
        @(negedge clk);
        rw_drv = 32'h00000015;
        req(2'b10, 12'h001, 4'b0001, 1'b1, 5'd0, {4{32'hFFFFFFFF}}, 32'h80000023);
        #1;
        check("rsi0_rd_en", csr_read_enable, 1'b1);
        check("rsi0_wr_en", csr_write_enable, 1'b0);
        @(posedge clk); #1;
        check("rsi0_out_data", out_data, {4{32'h00000015}});
        check("rsi0_out_wid", out_wid, 2'd3);

        // CSRRSI with zimm 6: 0x15 | 0x06 = 0x17.
        @(negedge clk);
        req(2'b10, 12'h001, 4'b0001, 1'b1, 5'd6, {4{32'hFFFFFFFF}}, 32'h80000024);
        #1;
        check("rsi6_wr_en", csr_write_enable, 1'b1);
        check("rsi6_wr_data", csr_write_data, 32'h00000017);

        // CSRRC from lane 2 only, old value via the read-only port: 0xFF & ~0x0F = 0xF0.
        @(negedge clk);
        rw_drv           = 32'h0;
        csr_read_data_ro = 32'h000000FF;
        req(2'b11, 12'h002, 4'b0100, 1'b0, 5'd0,
            {32'hFFFFFFFF, 32'h0000000F, 32'hFFFFFFFF, 32'hFFFFFFFF}, 32'h80000030);
        #1;
        check("rc_wr_en", csr_write_enable, 1'b1);
        check("rc_wr_data", csr_write_data, 32'h000000F0);
        @(posedge clk); #1;
        check("rc_out_data", out_data, {4{32'h000000FF}});
        check("rc_out_tmask", out_tmask, 4'b0100);

        // Empty mask falls back to lane 0; CSRRC with zero operand does not write.
        @(negedge clk);
        csr_read_data_ro = 32'h0;
        rw_drv           = 32'h0000F0F0;
        req(2'b01, 12'h003, 4'b0000, 1'b0, 5'd0,
            {32'h44444444, 32'h33333333, 32'h22222222, 32'hA5A5A5A5}, 32'h80000040);
        #1;
        check("m0_wr_data", csr_write_data, 32'hA5A5A5A5);
        @(negedge clk);
        req(2'b11, 12'h003, 4'b1010, 1'b0, 5'd0,
            {32'h44444444, 32'h33333333, 32'h00000000, 32'h11111111}, 32'h80000044);
        #1;
        check("rc0_wr_en", csr_write_enable, 1'b0);
        check("rc0_rd_en", csr_read_enable, 1'b1);
        idle_cycle("mid_drain");

        // Backpressure: first result held while a second request waits three cycles.
        @(negedge clk);
        out_ready = 1'b0;
        rw_drv    = 32'hAAAA0000;
        req(2'b01, 12'h305, 4'b0001, 1'b0, 5'd0, {96'h0, 32'h00000100}, 32'h80000050);
        #1;
        check("bp1_wr_en", csr_write_enable, 1'b1);
        @(posedge clk); #1;
        check("bp1_out_valid", out_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rw_drv = 32'h0000BBBB;
            req(2'b01, 12'h306, 4'b0001, 1'b0, 5'd0, {96'h0, 32'h00000200}, 32'h80000060);
            #1;
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_rd_en", csr_read_enable, 1'b0);
            check("bp_wr_en", csr_write_enable, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, {4{32'hAAAA0000}});
            check("bp_out_pc", out_pc, 32'h80000050);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp2_in_ready", in_ready, 1'b1);
        check("bp2_wr_en", csr_write_enable, 1'b1);
        check("bp2_wr_addr", csr_write_addr, 12'h306);
        check("bp2_wr_data", csr_write_data, 32'h00000200);
        @(posedge clk); #1;
        check("bp2_out_valid", out_valid, 1'b1);
        check("bp2_out_data", out_data, {4{32'h0000BBBB}});
        check("bp2_out_pc", out_pc, 32'h80000060);
        idle_cycle("bp_drain");

        // Back-to-back CSRRW then CSRR on 0x340 through the backing store.
        @(negedge clk);
        use_store = 1'b1;
        req(2'b01, 12'h340, 4'b0010, 1'b0, 5'd0,
            {32'h0, 32'h0, 32'h13572468, 32'h99999999}, 32'h80000070);
        #1;
        check("b2b_wr_data", csr_write_data, 32'h13572468);
        @(posedge clk); #1;
        check("b2b_first_old", out_data, {4{32'hDEADBEEF}});
        @(negedge clk);
        req(2'b00, 12'h340, 4'b0001, 1'b0, 5'd0, {4{32'h77777777}}, 32'h80000074);
        #1;
        check("b2b_rd_wr_en", csr_write_enable, 1'b0);
        check("b2b_rd_en", csr_read_enable, 1'b1);
        @(posedge clk); #1;
        check("b2b_second", out_data, {4{32'h13572468}});
        idle_cycle("b2b_drain");
        use_store = 1'b0;

        // Reset asserted with a result in flight discards it immediately.
        @(negedge clk);
        rw_drv = 32'h0C0C0C0C;
        req(2'b01, 12'h300, 4'b0001, 1'b0, 5'd0, {4{32'h1}}, 32'h80000080);
        @(posedge clk); #1;
        check("ar_pre_valid", out_valid, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_out_data", out_data, 128'h0);
        check("ar_out_uuid", out_uuid, 44'h0);
        check("ar_in_ready", in_ready, 1'b0);
`ifdef VX_CSR_RMW_PERF_EN
        check("ar_perf_reqs", perf_csr_reqs, 44'h0);
        check("ar_perf_stalls", perf_csr_stalls, 44'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ar_post_valid", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
